// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU datapath: sequences FETCH/DECODE/EXEC/WB,
// drives registered datapath strobes and counts retired instructions.
module multicycle_ctrl #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               mem_req,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               a_load,
    output logic               b_load,
    output logic [2:0]         rf_raddr_a,
    output logic [2:0]         rf_raddr_b,
    output logic [2:0]         alu_op,
    output logic               alu_r_load,
    output logic               rf_we,
    output logic [2:0]         rf_waddr,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           state_q;
    logic             stopSeen_q;
    logic             haltPend_q;
    logic             memReq_q;
    logic             irLoad_q;
    logic             pcInc_q;
    logic             aLoad_q;
    logic             bLoad_q;
    logic             aluRLoad_q;
    logic             rfWe_q;
    logic             halted_q;
    logic [2:0]       aluOp_q;
    logic [2:0]       rAddrA_q;
    logic [2:0]       rAddrB_q;
    logic [2:0]       wAddr_q;
    logic [CNT_W-1:0] retired_q;

    logic [2:0] opField;
    logic [2:0] rdField;
    logic [2:0] rsField;
    logic [2:0] rtField;
    logic       unusedInstrBits;

    assign opField         = instr[INSTR_W-1  -: 3];
    assign rdField         = instr[INSTR_W-4  -: 3];
    assign rsField         = instr[INSTR_W-7  -: 3];
    assign rtField         = instr[INSTR_W-10 -: 3];
    assign unusedInstrBits = ^instr[INSTR_W-11:0];

    // Strobes are computed on the edge that enters a state, so each pulse lines
    // up with the cycle the state register holds that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stopSeen_q <= 1'b0;
            haltPend_q <= 1'b0;
            memReq_q   <= 1'b0;
            irLoad_q   <= 1'b0;
            pcInc_q    <= 1'b0;
            aLoad_q    <= 1'b0;
            bLoad_q    <= 1'b0;
            aluRLoad_q <= 1'b0;
            rfWe_q     <= 1'b0;
            halted_q   <= 1'b0;
            aluOp_q    <= 3'b000;
            rAddrA_q   <= 3'b000;
            rAddrB_q   <= 3'b000;
            wAddr_q    <= 3'b000;
            retired_q  <= '0;
        end else begin
            memReq_q   <= 1'b0;
            irLoad_q   <= 1'b0;
            pcInc_q    <= 1'b0;
            aLoad_q    <= 1'b0;
            bLoad_q    <= 1'b0;
            aluRLoad_q <= 1'b0;
            rfWe_q     <= 1'b0;

            if (stop && state_q != IDLE && state_q != HALT) begin
                stopSeen_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FETCH;
                        memReq_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        state_q    <= DECODE;
                        irLoad_q   <= 1'b1;
                        pcInc_q    <= 1'b1;
                        haltPend_q <= (opField == OP_HALT);
                        // HALT is never forwarded: operand/ALU fields keep the last real op.
                        if (opField != OP_HALT) begin
                            aLoad_q  <= 1'b1;
                            bLoad_q  <= 1'b1;
                            aluOp_q  <= opField;
                            rAddrA_q <= rsField;
                            rAddrB_q <= rtField;
                            wAddr_q  <= rdField;
                        end
                    end else begin
                        memReq_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (haltPend_q) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= EXEC;
                        aluRLoad_q <= 1'b1;
                    end
                end
                EXEC: begin
                    state_q   <= WB;
                    rfWe_q    <= 1'b1;
                    retired_q <= retired_q + 1'b1;
                end
                WB: begin
                    if (stopSeen_q || stop) begin
                        state_q    <= IDLE;
                        stopSeen_q <= 1'b0;
                    end else begin
                        state_q  <= FETCH;
                        memReq_q <= 1'b1;
                    end
                end
                HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = memReq_q;
    assign ir_load    = irLoad_q;
    assign pc_inc     = pcInc_q;
    assign a_load     = aLoad_q;
    assign b_load     = bLoad_q;
    assign rf_raddr_a = rAddrA_q;
    assign rf_raddr_b = rAddrB_q;
    assign alu_op     = aluOp_q;
    assign alu_r_load = aluRLoad_q;
    assign rf_we      = rfWe_q;
    assign rf_waddr   = wAddr_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table for the main flow plus
// hand-written sequences for back-to-back ops, HALT, reset mid-instruction and wrap.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        memReady;
    logic [15:0] instr;
    logic        memReq;
    logic        irLoad;
    logic        pcInc;
    logic        aLoad;
    logic        bLoad;
    logic [2:0]  rAddrA;
    logic [2:0]  rAddrB;
    logic [2:0]  aluOp;
    logic        aluRLoad;
    logic        rfWe;
    logic [2:0]  wAddr;
    logic        halted;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.INSTR_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mem_ready (memReady),
        .instr     (instr),
        .mem_req   (memReq),
        .ir_load   (irLoad),
        .pc_inc    (pcInc),
        .a_load    (aLoad),
        .b_load    (bLoad),
        .rf_raddr_a(rAddrA),
        .rf_raddr_b(rAddrB),
        .alu_op    (aluOp),
        .alu_r_load(aluRLoad),
        .rf_we     (rfWe),
        .rf_waddr  (wAddr),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe byte order: {mem_req, ir_load, pc_inc, a_load, b_load, alu_r_load, rf_we, halted}
    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic        memReady;
        logic [15:0] instr;
        logic [7:0]  strobes;
        logic [2:0]  aluOp;
        logic [2:0]  rAddrA;
        logic [2:0]  rAddrB;
        logic [2:0]  wAddr;
        logic [15:0] retired;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic s, logic p, logic m, logic [15:0] ins,
                                logic [7:0] st, logic [2:0] op, logic [2:0] ra,
                                logic [2:0] rb, logic [2:0] wa, logic [15:0] ret);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.memReady = m; v.instr = ins;
        v.strobes = st; v.aluOp = op; v.rAddrA = ra; v.rAddrB = rb; v.wAddr = wa;
        v.retired = ret;
        return v;
    endfunction

    function automatic logic [35:0] pack(logic [7:0] st, logic [2:0] op, logic [2:0] ra,
                                         logic [2:0] rb, logic [2:0] wa, logic [15:0] ret);
        return {st, op, ra, rb, wa, ret};
    endfunction

    function automatic logic [35:0] snapshot();
        return {memReq, irLoad, pcInc, aLoad, bLoad, aluRLoad, rfWe, halted,
                aluOp, rAddrA, rAddrB, wAddr, retired};
    endfunction

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic m, input logic [15:0] ins);
        rst = r; start = s; stop = p; memReady = m; instr = ins;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [35:0] exp);
        logic [35:0] act;
        act = snapshot();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got strobes=%b op=%0d ra=%0d rb=%0d wa=%0d ret=%h, expected strobes=%b op=%0d ra=%0d rb=%0d wa=%0d ret=%h",
                     name, act[35:28], act[27:25], act[24:22], act[21:19], act[18:16], act[15:0],
                     exp[35:28], exp[27:25], exp[24:22], exp[21:19], exp[18:16], exp[15:0]);
        end
    endtask

    localparam logic [15:0] ADD_I  = 16'h4530; // add rd=1 rs=2 rt=3
    localparam logic [15:0] SUB_I  = 16'h72E0; // sub rd=4 rs=5 rt=6
    localparam logic [15:0] HALT_I = 16'hFFF0;

    initial begin
        logic [2:0]  o;
        logic [15:0] ins;

        vecs[0]  = mk(0,1,0,0,16'h0000, 8'b1000_0000, 3'd0,3'd0,3'd0,3'd0, 16'd0);
        vecs[1]  = mk(0,0,0,1,ADD_I,    8'b0111_1000, 3'd2,3'd2,3'd3,3'd1, 16'd0);
        vecs[2]  = mk(0,0,0,0,16'h0000, 8'b0000_0100, 3'd2,3'd2,3'd3,3'd1, 16'd0);
        vecs[3]  = mk(0,0,0,0,16'h0000, 8'b0000_0010, 3'd2,3'd2,3'd3,3'd1, 16'd1);
        vecs[4]  = mk(0,0,0,0,16'h0000, 8'b1000_0000, 3'd2,3'd2,3'd3,3'd1, 16'd1);
        vecs[5]  = mk(0,0,0,0,16'hE000, 8'b1000_0000, 3'd2,3'd2,3'd3,3'd1, 16'd1);
        vecs[6]  = mk(0,0,0,0,16'hE000, 8'b1000_0000, 3'd2,3'd2,3'd3,3'd1, 16'd1);
        vecs[7]  = mk(0,0,0,0,16'hE000, 8'b1000_0000, 3'd2,3'd2,3'd3,3'd1, 16'd1);
        vecs[8]  = mk(0,0,0,1,SUB_I,    8'b0111_1000, 3'd3,3'd5,3'd6,3'd4, 16'd1);
        vecs[9]  = mk(0,0,0,0,16'h0000, 8'b0000_0100, 3'd3,3'd5,3'd6,3'd4, 16'd1);
        vecs[10] = mk(0,0,1,0,16'h0000, 8'b0000_0010, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[11] = mk(0,0,0,0,16'h0000, 8'b0000_0000, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[12] = mk(0,0,0,0,16'h0000, 8'b0000_0000, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[13] = mk(0,0,0,1,ADD_I,    8'b0000_0000, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[14] = mk(0,0,1,0,16'h0000, 8'b0000_0000, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[15] = mk(0,1,1,0,16'h0000, 8'b1000_0000, 3'd3,3'd5,3'd6,3'd4, 16'd2);
        vecs[16] = mk(0,0,0,1,ADD_I,    8'b0111_1000, 3'd2,3'd2,3'd3,3'd1, 16'd2);
        vecs[17] = mk(0,0,0,0,16'h0000, 8'b0000_0100, 3'd2,3'd2,3'd3,3'd1, 16'd2);
        vecs[18] = mk(0,0,0,0,16'h0000, 8'b0000_0010, 3'd2,3'd2,3'd3,3'd1, 16'd3);
        vecs[19] = mk(0,0,0,0,16'h0000, 8'b1000_0000, 3'd2,3'd2,3'd3,3'd1, 16'd3);

        applyStimulus(1,0,0,0,16'h0000);
        checkOutput("reset", pack(8'h00, 3'd0,3'd0,3'd0,3'd0, 16'd0));

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].memReady, vecs[i].instr);
            checkOutput($sformatf("vec%0d", i),
                        pack(vecs[i].strobes, vecs[i].aluOp, vecs[i].rAddrA, vecs[i].rAddrB,
                             vecs[i].wAddr, vecs[i].retired));
        end

        // Seven ops back to back: 28 edges from the start edge to the seventh WB.
        applyStimulus(1,0,0,0,16'h0000);
        applyStimulus(0,1,0,0,16'h0000);
        for (int k = 0; k < 7; k++) begin
            o   = 3'(k);
            ins = {o, o, 3'(o + 3'd1), 3'(o + 3'd2), 4'h0};
            applyStimulus(0,0,0,1,ins);
            applyStimulus(0,0,0,0,16'h0000);
            checkOutput($sformatf("b2b_exec%0d", k),
                        pack(8'b0000_0100, o, 3'(o + 3'd1), 3'(o + 3'd2), o, 16'(k)));
            applyStimulus(0,0,0,0,16'h0000);
            if (k != 6) applyStimulus(0,0,0,0,16'h0000);
        end
        checkOutput("b2b_wb7", pack(8'b0000_0010, 3'd6,3'd7,3'd0,3'd6, 16'd7));
        applyStimulus(0,0,1,0,16'h0000);
        checkOutput("b2b_stop_in_wb", pack(8'h00, 3'd6,3'd7,3'd0,3'd6, 16'd7));

        // HALT: fields and counter frozen, start/stop ignored.
        applyStimulus(0,1,0,0,16'h0000);
        applyStimulus(0,0,0,1,HALT_I);
        checkOutput("halt_decode", pack(8'b0110_0000, 3'd6,3'd7,3'd0,3'd6, 16'd7));
        applyStimulus(0,0,0,0,16'h0000);
        checkOutput("halt_enter", pack(8'b0000_0001, 3'd6,3'd7,3'd0,3'd6, 16'd7));
        applyStimulus(0,1,0,0,16'h0000);
        checkOutput("halt_start", pack(8'b0000_0001, 3'd6,3'd7,3'd0,3'd6, 16'd7));
        applyStimulus(0,1,1,1,ADD_I);
        checkOutput("halt_stay", pack(8'b0000_0001, 3'd6,3'd7,3'd0,3'd6, 16'd7));

        // Reset in EXEC suppresses the writeback; then counter wrap.
        applyStimulus(1,0,0,0,16'h0000);
        checkOutput("halt_reset", pack(8'h00, 3'd0,3'd0,3'd0,3'd0, 16'd0));
        applyStimulus(0,1,0,0,16'h0000);
        applyStimulus(0,0,0,1,ADD_I);
        applyStimulus(0,0,0,0,16'h0000);
        checkOutput("rst_exec_pre", pack(8'b0000_0100, 3'd2,3'd2,3'd3,3'd1, 16'd0));
        applyStimulus(1,0,0,0,16'h0000);
        checkOutput("rst_exec", pack(8'h00, 3'd0,3'd0,3'd0,3'd0, 16'd0));
        applyStimulus(0,0,0,0,16'h0000);
        checkOutput("rst_exec_after", pack(8'h00, 3'd0,3'd0,3'd0,3'd0, 16'd0));

        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        applyStimulus(0,1,0,0,16'h0000);
        checkOutput("wrap_fetch", pack(8'b1000_0000, 3'd0,3'd0,3'd0,3'd0, 16'hFFFF));
        applyStimulus(0,0,0,1,ADD_I);
        applyStimulus(0,0,0,0,16'h0000);
        applyStimulus(0,0,0,0,16'h0000);
        checkOutput("wrap_wb", pack(8'b0000_0010, 3'd2,3'd2,3'd3,3'd1, 16'h0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
